knn_controller: RTL and testbench

Top-level sequencer for one KNN inference pass over a training set of 2^L vectors.
- Walks training memory addresses 0..2^L-1 and hands each vector to the distance calculator with a read_done pulse.
- Counts distance-done events, then fires the sort trigger and waits for the k-type vote.
- Returns the inferred type through a valid/ready result port.
- Sits between the host/testbench, the training memory and the KNN datapath; replaces ad-hoc done counting in the datapath wrapper.

---
 rtl/knn_controller_pkg.sv | 24 ++
 rtl/knn_watchdog.sv | 44 ++++
 rtl/knn_controller.sv | 206 ++++++++++++++++++++
 tb/tb_knn_controller.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_controller_pkg.sv
// Shared types and defaults for the KNN inference sequencer.
// Contents: controller state enum, default widths, wait-state helper.
package knn_controller_pkg;

  localparam int unsigned DefaultL        = 6;
  localparam int unsigned DefaultTypeW    = 3;
  localparam int unsigned DefaultTimeoutW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitMem,
    StWaitDist,
    StSort,
    StWaitInf,
    StResult
  } knn_state_e;

  // States in which the controller is blocked on an external agent.
  function automatic logic is_wait_state(knn_state_e s);
    return (s == StWaitMem) || (s == StWaitDist) || (s == StWaitInf);
  endfunction

endpackage

// File: rtl/knn_watchdog.sv
// Idle-wait watchdog: counts enabled cycles and flags the cycle in which the
// count is about to reach all-ones, so the owner can bail out on that edge.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - zero the counter (takes priority over enable)
//   enable    - count this cycle
//   expire    - high when an enabled count would reach all-ones this edge
module knn_watchdog
  import knn_controller_pkg::*;
#(
  parameter int unsigned Width = DefaultTimeoutW
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [Width-1:0] ExpireAt = {{(Width-1){1'b1}}, 1'b0};

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + Width'(1);
    end
  end

  // Independent of clear so the owner may derive clear from its next state.
  assign expire = enable && (count_q == ExpireAt);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/knn_controller.sv
// Top-level sequencer for one KNN inference pass over 2^L training vectors.
// Walks training memory, hands each vector to the distance datapath, triggers
// the sort, and returns the voted label on a valid/ready result port.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   start, abort                   - begin a pass (IDLE only) / cancel a pass
//   busy                           - high outside IDLE
//   mem_rd_en, mem_addr            - training memory read strobe and index
//   mem_rd_valid                   - training memory data valid (latency >= 1)
//   dp_data_request, dp_read_done  - datapath ready / vector-valid pulse
//   dp_done                        - distance for the current vector written
//   sort_start                     - one-cycle sort trigger
//   inference_done, inferred_type  - vote complete and its label
//   result_valid/ready/type        - result handshake and latched label
//   vec_count                      - vectors completed in the current pass
//   error                          - sticky watchdog flag
// All outputs come straight from registers.
module knn_controller
  import knn_controller_pkg::*;
#(
  parameter int unsigned L         = DefaultL,
  parameter int unsigned TYPE_W    = DefaultTypeW,
  parameter int unsigned TIMEOUT_W = DefaultTimeoutW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [L-1:0]      mem_addr,
  input  logic              mem_rd_valid,
  input  logic              dp_data_request,
  output logic              dp_read_done,
  input  logic              dp_done,
  output logic              sort_start,
  input  logic              inference_done,
  input  logic [TYPE_W-1:0] inferred_type,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [TYPE_W-1:0] result_type,
  output logic [L:0]        vec_count,
  output logic              error
);

  localparam logic [L-1:0] LastIdx = '1;

  knn_state_e        state_q, state_d;
  logic [L-1:0]      index_q, index_d;
  logic [L:0]        vec_count_q, vec_count_d;
  logic              error_q, error_d;
  logic              result_valid_q, result_valid_d;
  logic [TYPE_W-1:0] result_type_q, result_type_d;
  logic [L-1:0]      mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              dp_read_done_q, dp_read_done_d;
  logic              sort_start_q, sort_start_d;
  logic              timeout;
  logic              wd_clear, wd_enable, wd_expire;

  // Watchdog restarts on every state change and only counts in wait states.
  assign wd_clear  = (state_d != state_q);
  assign wd_enable = is_wait_state(state_q);

  knn_watchdog #(
    .Width (TIMEOUT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    vec_count_d    = vec_count_q;
    error_d        = error_q;
    result_valid_d = result_valid_q;
    result_type_d  = result_type_q;
    mem_addr_d     = mem_addr_q;
    mem_rd_en_d    = 1'b0;
    dp_read_done_d = 1'b0;
    sort_start_d   = 1'b0;
    timeout        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFetch;
          index_d     = '0;
          vec_count_d = '0;
          error_d     = 1'b0;
        end
      end
      StFetch: begin
        if (dp_data_request) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = index_q;
          state_d     = StWaitMem;
        end
      end
      StWaitMem: begin
        // Data cannot return while the strobe is still up (latency >= 1).
        if (mem_rd_valid && !mem_rd_en_q) begin
          dp_read_done_d = 1'b1;
          state_d        = StWaitDist;
        end else if (wd_expire) begin
          timeout = 1'b1;
        end
      end
      StWaitDist: begin
        if (dp_done) begin
          vec_count_d = vec_count_q + (L+1)'(1);
          if (index_q == LastIdx) begin
            sort_start_d = 1'b1;
            state_d      = StSort;
          end else begin
            index_d = index_q + L'(1);
            state_d = StFetch;
          end
        end else if (wd_expire) begin
          timeout = 1'b1;
        end
      end
      StSort: begin
        state_d = StWaitInf;
      end
      StWaitInf: begin
        if (inference_done) begin
          result_type_d  = inferred_type;
          result_valid_d = 1'b1;
          state_d        = StResult;
        end else if (wd_expire) begin
          timeout = 1'b1;
        end
      end
      StResult: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (timeout) begin
      state_d = StIdle;
      error_d = 1'b1;
    end

    // Abort discards everything this cycle decided, except the sticky error.
    if (abort) begin
      state_d        = StIdle;
      index_d        = index_q;
      vec_count_d    = vec_count_q;
      error_d        = error_q;
      result_valid_d = 1'b0;
      result_type_d  = result_type_q;
      mem_addr_d     = mem_addr_q;
      mem_rd_en_d    = 1'b0;
      dp_read_done_d = 1'b0;
      sort_start_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      index_q        <= '0;
      vec_count_q    <= '0;
      error_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_type_q  <= '0;
      mem_addr_q     <= '0;
      mem_rd_en_q    <= 1'b0;
      dp_read_done_q <= 1'b0;
      sort_start_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      vec_count_q    <= vec_count_d;
      error_q        <= error_d;
      result_valid_q <= result_valid_d;
      result_type_q  <= result_type_d;
      mem_addr_q     <= mem_addr_d;
      mem_rd_en_q    <= mem_rd_en_d;
      dp_read_done_q <= dp_read_done_d;
      sort_start_q   <= sort_start_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_addr     = mem_addr_q;
  assign dp_read_done = dp_read_done_q;
  assign sort_start   = sort_start_q;
  assign result_valid = result_valid_q;
  assign result_type  = result_type_q;
  assign vec_count    = vec_count_q;
  assign error        = error_q;

endmodule

// File: tb/tb_knn_controller.sv
// Bench for knn_controller with L=2, TYPE_W=3, TIMEOUT_W=4. The stimulus
// process plays memory, datapath and result consumer; for every pass it
// queues the expected sequence of DUT output events, and a negedge monitor
// pops and compares them as the DUT produces them.
module tb_knn_controller;

  localparam int unsigned L         = 2;
  localparam int unsigned TYPE_W    = 3;
  localparam int unsigned TIMEOUT_W = 4;
  localparam int unsigned N         = 1 << L;

  localparam int EvRd   = 0;
  localparam int EvRdn  = 1;
  localparam int EvSort = 2;
  localparam int EvRes  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy;
  logic              mem_rd_en;
  logic [L-1:0]      mem_addr;
  logic              mem_rd_valid = 1'b0;
  logic              dp_data_request = 1'b0;
  logic              dp_read_done;
  logic              dp_done = 1'b0;
  logic              sort_start;
  logic              inference_done = 1'b0;
  logic [TYPE_W-1:0] inferred_type = '0;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic [TYPE_W-1:0] result_type;
  logic [L:0]        vec_count;
  logic              error;

  knn_controller #(
    .L         (L),
    .TYPE_W    (TYPE_W),
    .TIMEOUT_W (TIMEOUT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .busy            (busy),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rd_valid    (mem_rd_valid),
    .dp_data_request (dp_data_request),
    .dp_read_done    (dp_read_done),
    .dp_done         (dp_done),
    .sort_start      (sort_start),
    .inference_done  (inference_done),
    .inferred_type   (inferred_type),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_type     (result_type),
    .vec_count       (vec_count),
    .error           (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  last_type = 0;
  int  exp_vc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event_order: got kind %0d val %0d, expected kind %0d val %0d",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) observe(EvRd, int'(mem_addr));
      if (dp_read_done) observe(EvRdn, 0);
      if (sort_start) observe(EvSort, 0);
      if (result_valid && result_ready) observe(EvRes, int'({vec_count, result_type}));
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      EvRd:    return mem_rd_en;
      EvRdn:   return dp_read_done;
      EvSort:  return sort_start;
      default: return result_valid;
    endcase
  endfunction

  task automatic wait_high(input int sel, input string name);
    int n = 0;
    while (!sig(sel) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!sig(sel)) begin
      errors++;
      $display("FAIL wait_%s: got 0 after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({busy, mem_rd_en, mem_addr, dp_read_done, sort_start, result_valid,
                     result_type, vec_count, error}), 32'd0);
  endtask

  task automatic drain(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_pass(input bit fixed, input bit do_abort, input int abort_vec,
                         input bit rst_in_result);
    int typ, lat, dly, bp, hold, nv;
    typ = fixed ? 5 : int'($urandom_range(0, 7));
    nv  = do_abort ? abort_vec + 1 : int'(N);
    for (int i = 0; i < nv; i++) begin
      push(EvRd, i);
      push(EvRdn, 0);
    end
    if (!do_abort) begin
      push(EvSort, 0);
      push(EvRes, (int'(N) << TYPE_W) | typ);
    end

    // Stray datapath pulses in IDLE change nothing.
    dp_done = 1'b1;
    inference_done = 1'b1;
    inferred_type = TYPE_W'($urandom);
    tick();
    dp_done = 1'b0;
    inference_done = 1'b0;
    check("idle_stray_busy", busy, 0);
    check("idle_stray_vec_count", vec_count, exp_vc);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_vec_count", vec_count, 0);
    check("start_error_cleared", error, 0);
    exp_vc = 0;

    for (int i = 0; i < nv; i++) begin
      bp = fixed ? ((i == 0) ? 10 : 0) : int'($urandom_range(0, 3));
      dp_data_request = 1'b0;
      repeat (bp) begin
        check("backpressure_no_read", mem_rd_en, 0);
        tick();
      end
      dp_data_request = 1'b1;
      wait_high(EvRd, "mem_rd_en");
      dp_data_request = 1'b0;
      lat = fixed ? 2 : int'($urandom_range(1, 4));
      // A valid in the strobe cycle itself must be ignored.
      mem_rd_valid = fixed ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      mem_rd_valid = 1'b0;
      repeat (lat - 1) tick();
      mem_rd_valid = 1'b1;
      tick();
      mem_rd_valid = 1'b0;
      wait_high(EvRdn, "dp_read_done");
      check("vec_count_progress", vec_count, i);
      dly = fixed ? 3 : int'($urandom_range(1, 4));
      start = fixed ? (i == 1) : 1'($urandom_range(0, 1));
      repeat (dly) begin
        tick();
        start = 1'b0;
      end
      dp_done = 1'b1;
      if (do_abort && i == abort_vec) abort = 1'b1;
      tick();
      dp_done = 1'b0;
      if (abort) begin
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_vec_count", vec_count, abort_vec);
        check("abort_result_valid", result_valid, 0);
        exp_vc = abort_vec;
        repeat (3) tick();
        drain("abort_queue_drained");
        return;
      end
      exp_vc = i + 1;
    end

    wait_high(EvSort, "sort_start");
    check("sort_vec_count", vec_count, N);
    dly = fixed ? 2 : int'($urandom_range(1, 4));
    repeat (dly) tick();
    inference_done = 1'b1;
    inferred_type = TYPE_W'(typ);
    tick();
    inference_done = 1'b0;
    inferred_type = TYPE_W'(typ) ^ '1;
    wait_high(EvRes, "result_valid");

    if (rst_in_result) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("reset_mid_result");
      exp_vc = 0;
      last_type = 0;
      exp_q.delete();
      return;
    end

    hold = fixed ? 5 : int'($urandom_range(0, 3));
    repeat (hold) begin
      check("hold_result_valid", result_valid, 1);
      check("hold_result_type", result_type, typ);
      check("hold_busy", busy, 1);
      inference_done = 1'b1;  // stray vote outside WAIT_INF
      inferred_type = TYPE_W'($urandom);
      tick();
    end
    inference_done = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("accept_busy", busy, 0);
    check("accept_result_valid", result_valid, 0);
    check("accept_result_type", result_type, typ);
    check("accept_vec_count", vec_count, N);
    last_type = typ;
    exp_vc = N;
    drain("pass_queue_drained");
  endtask

  task automatic watchdog_test();
    push(EvRd, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    dp_data_request = 1'b1;
    wait_high(EvRd, "wd_mem_rd_en");
    dp_data_request = 1'b0;
    // Memory never answers: 15 wait cycles, then back to IDLE with error.
    repeat (14) tick();
    check("wd_busy_before", busy, 1);
    check("wd_error_before", error, 0);
    tick();
    check("wd_busy_after", busy, 0);
    check("wd_error_after", error, 1);
    check("wd_result_type_kept", result_type, last_type);
    check("wd_vec_count", vec_count, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wd_error_sticky_abort", error, 1);
    exp_vc = 0;
    drain("wd_queue_drained");
  endtask

  initial begin
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset_idle");

    do_pass(1'b1, 1'b0, 0, 1'b0);
    do_pass(1'b0, 1'b1, 2, 1'b0);
    do_pass(1'b0, 1'b0, 0, 1'b0);
    watchdog_test();
    do_pass(1'b0, 1'b0, 0, 1'b0);
    for (int p = 0; p < 8; p++) begin
      do_pass(1'b0, ($urandom_range(0, 2) == 0), int'($urandom_range(0, N - 1)), 1'b0);
    end
    do_pass(1'b0, 1'b0, 0, 1'b1);
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
